// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC generator around the BTB, with an in-flight
// prediction FIFO checked against execute-stage resolution.
// Ports: fpc_clk/fpc_reset (async, active-high), fpc_stall;
//   fetch side: fpc_pc, fpc_fetch_valid, fpc_btb_valid_prediction, fpc_btb_target;
//   resolve side: fpc_resolve_valid/_pc/_is_branch/_taken/_target;
//   outputs: fpc_flush, fpc_btb_write/_new_pc/_data/_branch_taken, fpc_mispredict_count.
// Optional: define FPC_MISPREDICT_COUNT_EN for a saturating mispredict counter.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          INSTR_BYTES = 4
) (
  input  logic        fpc_clk,
  input  logic        fpc_reset,
  input  logic        fpc_stall,
  output logic [31:0] fpc_pc,
  output logic        fpc_fetch_valid,
  input  logic        fpc_btb_valid_prediction,
  input  logic [31:0] fpc_btb_target,
  input  logic        fpc_resolve_valid,
  input  logic [31:0] fpc_resolve_pc,
  input  logic        fpc_resolve_is_branch,
  input  logic        fpc_resolve_taken,
  input  logic [31:0] fpc_resolve_target,
  output logic        fpc_flush,
  output logic        fpc_btb_write,
  output logic [31:0] fpc_btb_new_pc,
  output logic [31:0] fpc_btb_data,
  output logic        fpc_btb_branch_taken,
  output logic [15:0] fpc_mispredict_count
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] INC     = 32'(INSTR_BYTES);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] ONE_C   = (PW+1)'(1);
  localparam logic [PW-1:0] PONE  = PW'(1);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          flush_q, flush_d;
  logic          wr_q, wr_d;
  logic [31:0]   new_pc_q, new_pc_d;
  logic [31:0]   data_q, data_d;
  logic          tkn_q, tkn_d;
  logic [31:0]   fifo_pc_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_d [FIFO_DEPTH];
  logic [31:0]   fifo_tgt_q [FIFO_DEPTH];
  logic [31:0]   fifo_tgt_d [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wp_q, wp_d;
  logic [PW:0]   cnt_q, cnt_d;

  logic        full, empty, hit;
  logic [31:0] head_pc, head_tgt;
  logic        taken_br, pred_taken, mispredict;
  logic [31:0] correct_pc;
  logic        push, pop, hold_run, hold_hold;

  always_comb begin
    full       = (cnt_q == DEPTH_C);
    empty      = (cnt_q == '0);
    hit        = fpc_btb_valid_prediction;
    head_pc    = fifo_pc_q[rd_q];
    head_tgt   = fifo_tgt_q[rd_q];
    taken_br   = fpc_resolve_is_branch & fpc_resolve_taken;
    pred_taken = fpc_resolve_valid & ~empty
               & (head_pc == fpc_resolve_pc);
    mispredict = fpc_resolve_valid
               & ((pred_taken & ~taken_br)
               |  (~pred_taken & taken_br)
               |  (pred_taken & taken_br
                   & (head_tgt != fpc_resolve_target)));
    correct_pc = taken_br ? fpc_resolve_target
                          : fpc_resolve_pc + INC;
    pop        = pred_taken;
    // A pop in RUN cannot free a slot in time for this cycle's push,
    // but in HOLD it lets the next RUN cycle push the retried hit.
    hold_run   = fpc_stall | (hit & full);
    hold_hold  = fpc_stall | (hit & full & ~pop);
    // The redirect cycle's hit belongs to a squashed path context.
    push       = (state_q == RUN) & hit & ~full
               & ~flush_q & ~mispredict;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (mispredict) begin
      state_d = RUN;
      pc_d    = correct_pc;
    end else begin
      unique case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (hold_run)  state_d = HOLD;
          else if (hit)  pc_d = fpc_btb_target;
          else           pc_d = pc_q + INC;
        end
        HOLD: if (!hold_hold) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    fifo_pc_d  = fifo_pc_q;
    fifo_tgt_d = fifo_tgt_q;
    rd_d       = rd_q;
    wp_d       = wp_q;
    cnt_d      = cnt_q;
    if (mispredict) begin
      rd_d  = '0;
      wp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        fifo_pc_d[wp_q]  = pc_q;
        fifo_tgt_d[wp_q] = fpc_btb_target;
        wp_d             = wp_q + PONE;
      end
      if (pop) rd_d = rd_q + PONE;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + ONE_C;
        2'b01:   cnt_d = cnt_q - ONE_C;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    flush_d  = mispredict;
    wr_d     = fpc_resolve_valid & (taken_br | pred_taken);
    new_pc_d = new_pc_q;
    data_d   = data_q;
    tkn_d    = tkn_q;
    if (wr_d) begin
      new_pc_d = fpc_resolve_pc;
      data_d   = taken_br ? fpc_resolve_target : 32'h0;
      tkn_d    = taken_br;
    end
  end

  always_ff @(posedge fpc_clk or posedge fpc_reset) begin
    if (fpc_reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      flush_q  <= 1'b0;
      wr_q     <= 1'b0;
      new_pc_q <= '0;
      data_q   <= '0;
      tkn_q    <= 1'b0;
      rd_q     <= '0;
      wp_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]  <= '0;
        fifo_tgt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      wr_q       <= wr_d;
      new_pc_q   <= new_pc_d;
      data_q     <= data_d;
      tkn_q      <= tkn_d;
      rd_q       <= rd_d;
      wp_q       <= wp_d;
      cnt_q      <= cnt_d;
      fifo_pc_q  <= fifo_pc_d;
      fifo_tgt_q <= fifo_tgt_d;
    end
  end

`ifdef FPC_MISPREDICT_COUNT_EN
  logic [15:0] mcnt_q, mcnt_d;

  always_comb begin
    mcnt_d = mcnt_q;
    if (mispredict && mcnt_q != 16'hFFFF)
      mcnt_d = mcnt_q + 16'd1;
  end

  always_ff @(posedge fpc_clk or posedge fpc_reset) begin
    if (fpc_reset) mcnt_q <= '0;
    else           mcnt_q <= mcnt_d;
  end

  assign fpc_mispredict_count = mcnt_q;
`else
  assign fpc_mispredict_count = 16'h0000;
`endif

  assign fpc_pc               = pc_q;
  assign fpc_fetch_valid      = (state_q == RUN);
  assign fpc_flush            = flush_q;
  assign fpc_btb_write        = wr_q;
  assign fpc_btb_new_pc       = new_pc_q;
  assign fpc_btb_data         = data_q;
  assign fpc_btb_branch_taken = tkn_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed-vector bench for fetch_pc_unit
// (RESET_PC=0x100, FIFO_DEPTH=4, INSTR_BYTES=4).
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] pc;
  logic        fvalid;
  logic        hit;
  logic [31:0] hit_tgt;
  logic        r_valid;
  logic [31:0] r_pc;
  logic        r_br;
  logic        r_tkn;
  logic [31:0] r_tgt;
  logic        flush;
  logic        bwr;
  logic [31:0] bpc;
  logic [31:0] bdata;
  logic        btkn;
  logic [15:0] mcnt;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit #(
    .RESET_PC   (32'h100),
    .FIFO_DEPTH (4),
    .INSTR_BYTES(4)
  ) dut (
    .fpc_clk                 (clk),
    .fpc_reset               (rst),
    .fpc_stall               (stall),
    .fpc_pc                  (pc),
    .fpc_fetch_valid         (fvalid),
    .fpc_btb_valid_prediction(hit),
    .fpc_btb_target          (hit_tgt),
    .fpc_resolve_valid       (r_valid),
    .fpc_resolve_pc          (r_pc),
    .fpc_resolve_is_branch   (r_br),
    .fpc_resolve_taken       (r_tkn),
    .fpc_resolve_target      (r_tgt),
    .fpc_flush               (flush),
    .fpc_btb_write           (bwr),
    .fpc_btb_new_pc          (bpc),
    .fpc_btb_data            (bdata),
    .fpc_btb_branch_taken    (btkn),
    .fpc_mispredict_count    (mcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic res(input logic v, input logic [31:0] p,
                     input logic b, input logic t,
                     input logic [31:0] tg);
    r_valid = v;
    r_pc    = p;
    r_br    = b;
    r_tkn   = t;
    r_tgt   = tg;
  endtask

  function automatic logic [31:0] ecnt(input int n);
`ifdef FPC_MISPREDICT_COUNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    hit = 1'b0;
    hit_tgt = '0;
    res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("rst_pc", pc, 32'h100);
    chk("rst_fv", 32'(fvalid), 32'h0);
    chk("rst_wr", 32'(bwr), 32'h0);
    chk("rst_fl", 32'(flush), 32'h0);
    chk("rst_cnt", 32'(mcnt), 32'h0);
    tick();
    rst = 1'b0;
    chk("boot_pc", pc, 32'h100);
    chk("boot_fv", 32'(fvalid), 32'h0);

    tick();
    chk("run_pc0", pc, 32'h100);
    chk("run_fv", 32'(fvalid), 32'h1);
    tick();
    chk("seq_pc1", pc, 32'h104);
    tick();
    chk("seq_pc2", pc, 32'h108);
    hit = 1'b1; hit_tgt = 32'h200;
    tick();
    chk("hit_pc", pc, 32'h200);
    hit = 1'b0;
    res(1'b1, 32'h108, 1'b1, 1'b1, 32'h200);
    tick();
    chk("ok_fl", 32'(flush), 32'h0);
    chk("ok_wr", 32'(bwr), 32'h1);
    chk("ok_tk", 32'(btkn), 32'h1);
    chk("ok_npc", bpc, 32'h108);
    chk("ok_dat", bdata, 32'h200);
    chk("ok_pc", pc, 32'h204);
    res(1'b1, 32'h10C, 1'b1, 1'b1, 32'h300);
    tick();
    chk("mnt_fl", 32'(flush), 32'h1);
    chk("mnt_pc", pc, 32'h300);
    chk("mnt_fv", 32'(fvalid), 32'h1);
    chk("mnt_wr", 32'(bwr), 32'h1);
    chk("mnt_tk", 32'(btkn), 32'h1);
    chk("mnt_npc", bpc, 32'h10C);
    chk("mnt_dat", bdata, 32'h300);
    chk("mnt_cnt", 32'(mcnt), ecnt(1));
    res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("pls_fl", 32'(flush), 32'h0);
    chk("pls_wr", 32'(bwr), 32'h0);
    chk("hold_dat", bdata, 32'h300);
    chk("seq_pc3", pc, 32'h304);

    res(1'b1, 32'h300, 1'b1, 1'b1, 32'h140);
    tick();
    chk("rd1_pc", pc, 32'h140);
    chk("rd1_fl", 32'(flush), 32'h1);
    res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    hit = 1'b1; hit_tgt = 32'h400;
    tick();
    chk("rdhit_pc", pc, 32'h400);
    hit = 1'b0;
    res(1'b1, 32'h140, 1'b1, 1'b0, 32'h0);
    tick();
    chk("nopush_fl", 32'(flush), 32'h0);
    chk("nopush_wr", 32'(bwr), 32'h0);
    chk("nopush_pc", pc, 32'h404);
    res(1'b1, 32'h13C, 1'b1, 1'b1, 32'h140);
    tick();
    chk("rd2_pc", pc, 32'h140);
    chk("rd2_npc", bpc, 32'h13C);
    res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    stall = 1'b1;
    tick();
    chk("stl_pc", pc, 32'h140);
    chk("stl_fv", 32'(fvalid), 32'h0);
    stall = 1'b0;
    tick();
    chk("unstl_pc", pc, 32'h140);
    chk("unstl_fv", 32'(fvalid), 32'h1);
    hit = 1'b1; hit_tgt = 32'h400;
    tick();
    chk("h140_pc", pc, 32'h400);
    hit = 1'b0;
    res(1'b1, 32'h140, 1'b1, 1'b0, 32'h0);
    tick();
    chk("nt_fl", 32'(flush), 32'h1);
    chk("nt_pc", pc, 32'h144);
    chk("nt_wr", 32'(bwr), 32'h1);
    chk("nt_tk", 32'(btkn), 32'h0);
    chk("nt_npc", bpc, 32'h140);
    chk("nt_dat", bdata, 32'h0);
    chk("nt_cnt", 32'(mcnt), ecnt(4));
    tick();
    chk("empty_fl", 32'(flush), 32'h0);
    chk("empty_wr", 32'(bwr), 32'h0);
    chk("empty_pc", pc, 32'h148);
    res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    hit = 1'b1; hit_tgt = 32'h500;
    tick();
    chk("f1_pc", pc, 32'h500);
    hit_tgt = 32'h600;
    tick();
    chk("f2_pc", pc, 32'h600);
    hit_tgt = 32'h700;
    tick();
    chk("f3_pc", pc, 32'h700);
    hit_tgt = 32'h800;
    tick();
    chk("f4_pc", pc, 32'h800);
    hit_tgt = 32'h900;
    tick();
    chk("full_pc", pc, 32'h800);
    chk("full_fv", 32'(fvalid), 32'h0);
    tick();
    chk("full2_pc", pc, 32'h800);
    chk("full2_fv", 32'(fvalid), 32'h0);
    res(1'b1, 32'h148, 1'b1, 1'b1, 32'h500);
    tick();
    chk("pop_fv", 32'(fvalid), 32'h1);
    chk("pop_pc", pc, 32'h800);
    chk("pop_fl", 32'(flush), 32'h0);
    chk("pop_npc", bpc, 32'h148);
    res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("f5_pc", pc, 32'h900);
    hit = 1'b0;

    stall = 1'b1;
    res(1'b1, 32'h500, 1'b1, 1'b1, 32'h654);
    tick();
    chk("sm_fl", 32'(flush), 32'h1);
    chk("sm_pc", pc, 32'h654);
    chk("sm_fv", 32'(fvalid), 32'h1);
    chk("sm_dat", bdata, 32'h654);
    chk("sm_cnt", 32'(mcnt), ecnt(5));
    res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("sm2_pc", pc, 32'h654);
    chk("sm2_fv", 32'(fvalid), 32'h0);
    stall = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h100);
    chk("arst_fv", 32'(fvalid), 32'h0);
    chk("arst_npc", bpc, 32'h0);
    chk("arst_dat", bdata, 32'h0);
    chk("arst_cnt", 32'(mcnt), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rb_pc", pc, 32'h100);
    chk("rb_fv", 32'(fvalid), 32'h1);
    res(1'b1, 32'h100, 1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    chk("wrap0_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_cnt", 32'(mcnt), ecnt(1));
    res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap_pc", pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage PC generator that sits directly around branch_target_buffer.
- Drives the BTB lookup PC and consumes its prediction to choose the next fetch PC.
- Tracks in-flight predicted-taken fetches in a small in-order FIFO and checks them against execute-stage resolution.
- Produces the flush/redirect and the BTB update (write, new PC, target, taken) that feed back into branch_target_buffer.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 4, in-flight prediction entries; must be a power of 2, range 2..16.
- INSTR_BYTES, 4, sequential PC increment.

Ports:
- fpc_clk  in  1  clock, rising edge.
- fpc_reset  in  1  asynchronous, active-high reset.
- fpc_stall  in  1  decode stall: hold the PC.
- fpc_pc  out  32  current fetch PC; drives btb_pc and IMEM.
- fpc_fetch_valid  out  1  fpc_pc is a valid fetch this cycle.
- fpc_btb_valid_prediction  in  1  BTB hit for fpc_pc.
- fpc_btb_target  in  32  BTB predicted target.
- fpc_resolve_valid  in  1  one instruction leaves execute; in program order; one per cycle max.
- fpc_resolve_pc  in  32  PC of the resolving instruction.
- fpc_resolve_is_branch  in  1  resolving instruction is a branch/jump.
- fpc_resolve_taken  in  1  actual direction (ignored if not a branch).
- fpc_resolve_target  in  32  actual target.
- fpc_flush  out  1  one-cycle pulse: squash younger instructions.
- fpc_btb_write  out  1  one-cycle BTB update strobe.
- fpc_btb_new_pc  out  32  PC being written.
- fpc_btb_data  out  32  target being written.
- fpc_btb_branch_taken  out  1  1 = insert/update entry; 0 = invalidate entry.
- fpc_mispredict_count  out  16  mispredict counter (see optional feature).

Behaviour:
- Reset (async): fpc_pc=RESET_PC, fpc_fetch_valid=0, FIFO empty, all strobes 0, data outputs 0, FSM=BOOT.
- FSM:
  - BOOT→RUN on the first edge after reset; fpc_fetch_valid=1 from RUN onward.
  - RUN→HOLD when fpc_stall=1, or when a BTB hit occurs with the FIFO full.
  - HOLD→RUN when neither cause is present.
  - In HOLD: fpc_pc is held and fpc_fetch_valid=0.
- Next-PC priority, highest first:
  1. Mispredict redirect.
  2. Hold.
  3. BTB hit: fpc_btb_target.
  4. Otherwise fpc_pc+INSTR_BYTES.
  - All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- FIFO push: on a RUN cycle with fpc_btb_valid_prediction=1 and the FIFO not full, push {fpc_pc, fpc_btb_target}.
  - Full blocks the push even if a pop happens in the same cycle.
- Resolve check (cycle N, fpc_resolve_valid=1):
  - If the FIFO is non-empty and head.pc==fpc_resolve_pc: predicted taken to head.target; pop the head.
  - Otherwise: predicted not-taken; no pop.
  - Mispredict conditions:
    - predicted taken and not (is_branch and taken);
    - predicted not-taken and is_branch and taken;
    - predicted taken, taken, and head.target != fpc_resolve_target.
- On mispredict, in cycle N+1 (registered):
  - fpc_flush=1 for one cycle.
  - fpc_pc = correct path: resolve_target if taken branch, else resolve_pc+INSTR_BYTES.
  - fpc_fetch_valid=1.
  - FIFO cleared; FSM=RUN.
  - The N+1 cycle's fetch-side BTB hit is ignored for push but does steer the PC in N+2.
- BTB update, registered, fpc_btb_write pulses in N+1:
  - Taken branch (correct or not): branch_taken=1, new_pc=resolve_pc, data=resolve_target.
  - Predicted taken but not a taken branch: branch_taken=0, new_pc=resolve_pc, data=0.
  - Correct not-taken: no write.
- Simultaneous events:
  - A push in the same edge as a mispredict is discarded (flush wins).
  - Mispredict overrides fpc_stall for that single redirect cycle.
- Data outputs hold their last value when strobes are 0.
- Resolves while fpc_fetch_valid=0 are still processed.

Optional Feature:
- Macro FPC_MISPREDICT_COUNT_EN.
- Defined: fpc_mispredict_count increments by 1 on each mispredict, saturates at 16'hFFFF, and resets to 0.
- Undefined: no counter logic; fpc_mispredict_count tied to 16'h0000.

Test Plan:
- Reset with RESET_PC=32'h100, no hits, no stall → fpc_pc 0x100, 0x104, 0x108 on successive cycles; fpc_fetch_valid 0 in BOOT, then 1.
- Hit at 0x108 with target 0x200; later resolve pc 0x108, branch, taken, target 0x200 → next PC 0x200; FIFO pops; no flush; btb_write=1, taken=1, new_pc 0x108, data 0x200.
- No hit at 0x10C; resolve pc 0x10C, taken, target 0x300 → next cycle flush=1, fpc_pc=0x300, btb_write taken=1 data 0x300; counter=1 when the macro is defined.
- Hit at 0x140 predicted 0x400; resolve not-taken → flush, fpc_pc=0x144, btb_write branch_taken=0 new_pc 0x140, FIFO empty.
- FIFO_DEPTH=4 filled by 4 unresolved hits; 5th hit → HOLD, fpc_pc held, fetch_valid=0; one matching resolve pops → RUN resumes next cycle.
- fpc_stall=1 during a mispredict resolve → redirect PC still loads in N+1; assert async reset mid-run → outputs return to reset values immediately, without a clock edge.
